// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller
//
// 8 blocks x 16 bytes, 3-bit tag, zero-cycle hit, single outstanding fill.
// Ports:
//   CLK          clock, rising edge
//   RESET        synchronous active-low reset
//   PC           fetch address (tag PC[9:7], index PC[6:4], word PC[3:2])
//   INSTRUCTION  fetched word, zero while BUSYWAIT is high
//   BUSYWAIT     high while INSTRUCTION is not valid
//   mem_read     block read request to instruction memory
//   mem_address  block address {tag,index} of the fill in progress
//   mem_readdata 128-bit block returned by memory
//   mem_busywait high while the memory read is in progress
module icache_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [127:0] data_mem [8];
    logic [2:0]   tag_mem  [8];
    logic [7:0]   valid;

    logic [2:0] pc_tag;
    logic [2:0] pc_index;
    logic [1:0] pc_offset;
    logic       hit;
    logic       fill_done;
    logic       unused_pc;

    assign pc_tag    = PC[9:7];
    assign pc_index  = PC[6:4];
    assign pc_offset = PC[3:2];
    assign unused_pc = ^{PC[31:10], PC[1:0]};

    assign hit       = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
    // A fill completes on the MEM_READ edge where memory has dropped busywait.
    assign fill_done = (state == MEM_READ) && !mem_busywait;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= IDLE;
            valid       <= 8'h00;
            mem_address <= 6'd0;
        end else begin
            state <= next_state;
            // Address is captured once on the miss; later PC changes cannot
            // redirect the fill in progress.
            if (state == IDLE && !hit)
                mem_address <= {pc_tag, pc_index};
            if (fill_done)
                valid[mem_address[2:0]] <= 1'b1;
        end
    end

    // Tags and data are not reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (RESET && fill_done) begin
            data_mem[mem_address[2:0]] <= mem_readdata;
            tag_mem[mem_address[2:0]]  <= mem_address[5:3];
        end
    end

    always_comb begin
        next_state  = state;
        BUSYWAIT    = 1'b0;
        mem_read    = 1'b0;
        INSTRUCTION = 32'h0000_0000;
        if (RESET) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        INSTRUCTION = data_mem[pc_index][{pc_offset, 5'b00000} +: 32];
                    end else begin
                        BUSYWAIT   = 1'b1;
                        next_state = MEM_READ;
                    end
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    BUSYWAIT = 1'b1;
                    if (!mem_busywait)
                        next_state = UPDATE;
                end
                UPDATE: begin
                    BUSYWAIT   = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed self-checking bench for icache_ctrl
module tb_icache_ctrl;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int cnt   = 0;

    icache_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory: busy for lat cycles after mem_read rises; word k of block a
    // is (a << 8) | (k + 1).
    always @(posedge CLK) cnt <= mem_read ? cnt + 1 : 0;
    assign mem_busywait = mem_read && (cnt < lat);
    always_comb begin
        mem_readdata = '0;
        for (int k = 0; k < 4; k++)
            mem_readdata[32*k +: 32] = {18'h0, mem_address, 5'h0, 3'(k + 1)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge. Applies pc, optionally moves PC to wig
    // after the first mem_read cycle, and runs until BUSYWAIT drops.
    task automatic fetch(input string tag, input logic [31:0] pc, input int wig,
                         input int lat_i, input int exp_busy, input int exp_rd,
                         input logic [5:0] exp_addr, input int exp_nfirst,
                         input logic [31:0] exp_instr);
        int busy = 0, rd = 0, nfirst = 0, nonzero = 0;
        logic [5:0] first_addr = '0;
        logic done = 1'b0;
        lat = lat_i;
        PC  = pc;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (mem_read) begin
                if (rd == 0) first_addr = mem_address;
                if (mem_address == first_addr) nfirst++;
                rd++;
            end
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
            busy++;
            if (INSTRUCTION != 32'h0) nonzero++;
            @(posedge CLK);
            #1;
            if (wig >= 0 && rd == 1) PC = wig;
        end
        check({tag, ".timeout"}, {31'h0, done}, 32'd1);
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".rd"}, rd, exp_rd);
        check({tag, ".instr"}, INSTRUCTION, exp_instr);
        check({tag, ".zero"}, nonzero, 0);
        if (exp_rd > 0) begin
            check({tag, ".addr"}, {26'h0, first_addr}, {26'h0, exp_addr});
            check({tag, ".nfirst"}, nfirst, exp_nfirst);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        PC    = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst.busy", {31'h0, BUSYWAIT}, 32'd0);
        check("rst.rd", {31'h0, mem_read}, 32'd0);
        check("rst.instr", INSTRUCTION, 32'h0);
        check("rst.addr", {26'h0, mem_address}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // cold miss, N=4: 7 busy cycles, 5 mem_read cycles
        fetch("cold", 32'h000, -1, 4, 7, 5, 6'd0, 5, 32'h0000_0001);
        // spatial hits
        fetch("hit4", 32'h004, -1, 4, 0, 0, 6'd0, 0, 32'h0000_0002);
        fetch("hit8", 32'h008, -1, 4, 0, 0, 6'd0, 0, 32'h0000_0003);
        fetch("hitc", 32'h00C, -1, 4, 0, 0, 6'd0, 0, 32'h0000_0004);
        // conflict on index 0 with zero-latency memory
        fetch("conf1", 32'h080, -1, 0, 3, 1, 6'b001000, 1, 32'h0000_0801);
        fetch("conf0", 32'h000, -1, 0, 3, 1, 6'd0, 1, 32'h0000_0001);
        fetch("conf0h", 32'h008, -1, 0, 0, 0, 6'd0, 0, 32'h0000_0003);
        // PC wiggle during fill: block 1 completes, then 0x3F0 misses
        fetch("wig", 32'h010, 32'h3F0, 2, 10, 6, 6'd1, 3, 32'h0000_3F01);
        fetch("wig1h", 32'h014, -1, 0, 0, 0, 6'd0, 0, 32'h0000_0102);
        fetch("wig3fh", 32'h3FC, -1, 0, 0, 0, 6'd0, 0, 32'h0000_3F04);

        // reset during MEM_READ abandons the fill of block 2
        lat = 5;
        PC  = 32'h020;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("mid.rd_before", {31'h0, mem_read}, 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("mid.rd", {31'h0, mem_read}, 32'd0);
        check("mid.busy", {31'h0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        fetch("mid.pc10", 32'h010, -1, 0, 3, 1, 6'd1, 1, 32'h0000_0101);
        fetch("mid.pc20", 32'h024, -1, 0, 3, 1, 6'd2, 1, 32'h0000_0202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
